// File: rtl/ula_pkg.sv
// Shared types and function-select constants for the sliced 74181-style ALU.
package ula_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ula_estado_t;

  localparam logic [OP_W-1:0] OP_SOMA = 4'b1001;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
  localparam logic [OP_W-1:0] OP_UNS  = 4'b1100;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0110;

endpackage

// File: rtl/ula_fatiada_if.sv
// Request/result handshake bundle between requester, ALU and consumer.
interface ula_fatiada_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             co;
  logic             aeqb;
  logic             zero;

  modport master (
    output in_valid, a, b, s, m, ci, out_ready,
    input  in_ready, out_valid, f, co, aeqb, zero
  );

  modport slave (
    input  in_valid, a, b, s, m, ci, out_ready,
    output in_ready, out_valid, f, co, aeqb, zero
  );
endinterface

// File: rtl/ula_fatia.sv
// Combinational SLICE-bit 74181 function slice: logic ops or P+Q+cin per select.
module ula_fatia
  import ula_pkg::*;
#(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [OP_W-1:0]  s,
  input  logic             m,
  input  logic             cin,
  output logic [SLICE-1:0] f_c,
  output logic             cout_c
);
  localparam int unsigned SW = SLICE + 1;

  logic [SLICE-1:0] ones;
  logic [SLICE-1:0] p;
  logic [SLICE-1:0] q;
  logic [SW-1:0]    sum;

  always_comb begin
    ones   = '1;
    p      = '0;
    q      = '0;
    sum    = '0;
    f_c    = '0;
    cout_c = 1'b0;
    if (m) begin
      case (s)
        4'b0000: f_c = ~a;
        4'b0001: f_c = ~(a | b);
        4'b0010: f_c = ~a & b;
        4'b0011: f_c = '0;
        4'b0100: f_c = ~(a & b);
        4'b0101: f_c = ~b;
        4'b0110: f_c = a ^ b;
        4'b0111: f_c = a & ~b;
        4'b1000: f_c = ~a | b;
        4'b1001: f_c = ~(a ^ b);
        4'b1010: f_c = b;
        4'b1011: f_c = a & b;
        4'b1100: f_c = ones;
        4'b1101: f_c = a | ~b;
        4'b1110: f_c = a | b;
        default: f_c = a;
      endcase
    end else begin
      // Operand pair (P, Q) per select; every term is bitwise so slices stay independent.
      case (s)
        4'b0000: begin p = a;         q = '0;      end
        4'b0001: begin p = a | b;     q = '0;      end
        4'b0010: begin p = a | ~b;    q = '0;      end
        4'b0011: begin p = '0;        q = ones;    end
        4'b0100: begin p = a;         q = a & ~b;  end
        4'b0101: begin p = a | b;     q = a & ~b;  end
        4'b0110: begin p = a;         q = ~b;      end
        4'b0111: begin p = a & ~b;    q = ones;    end
        4'b1000: begin p = a;         q = a & b;   end
        4'b1001: begin p = a;         q = b;       end
        4'b1010: begin p = a | ~b;    q = a & b;   end
        4'b1011: begin p = a & b;     q = ones;    end
        OP_UNS:  begin p = a;         q = a;       end
        4'b1101: begin p = a | b;     q = a;       end
        4'b1110: begin p = a | ~b;    q = a;       end
        default: begin p = a;         q = ones;    end
      endcase
      sum    = {1'b0, p} + {1'b0, q} + SW'(cin);
      f_c    = sum[SLICE-1:0];
      cout_c = sum[SLICE];
    end
  end

endmodule

// File: rtl/ula_fatiada.sv
// Multi-cycle WIDTH-bit 74181 ALU: one SLICE-bit slice per clock, LSB first, registered carry.
module ula_fatiada
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic         clk,
  input  logic         rst,
  ula_fatiada_if.slave bus
);
  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (SLICE == 0 || (WIDTH % SLICE) != 0) begin : g_bad_param
    $error("ula_fatiada: WIDTH must be a non-zero multiple of SLICE");
  end

  ula_estado_t      state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OP_W-1:0]  s_q, s_d;
  logic             m_q, m_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             co_q, co_d;
  logic             aeqb_q, aeqb_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_f;
  logic             sl_cout;

  // Pick the operand slice addressed by the slice counter.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (k_q == KW'(i)) begin
        sl_a = a_q[i*SLICE +: SLICE];
        sl_b = b_q[i*SLICE +: SLICE];
      end
    end
  end

  ula_fatia #(.SLICE(SLICE)) u_fatia (
    .a      (sl_a),
    .b      (sl_b),
    .s      (s_q),
    .m      (m_q),
    .cin    (carry_q),
    .f_c    (sl_f),
    .cout_c (sl_cout)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    m_d         = m_q;
    f_d         = f_q;
    co_d        = co_q;
    aeqb_d      = aeqb_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.a;
          b_d        = bus.b;
          s_d        = bus.s;
          m_d        = bus.m;
          carry_d    = bus.ci & ~bus.m;
          k_d        = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NSLICE; i++) begin
          if (k_q == KW'(i)) f_d[i*SLICE +: SLICE] = sl_f;
        end
        carry_d = sl_cout;
        k_d     = k_q + KW'(1);
        // Last slice: flags come from the completed result.
        if (k_q == KW'(NSLICE - 1)) begin
          k_d         = '0;
          co_d        = sl_cout & ~m_q;
          aeqb_d      = &f_d;
          zero_d      = ~|f_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      m_q         <= 1'b0;
      f_q         <= '0;
      co_q        <= 1'b0;
      aeqb_q      <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      m_q         <= m_d;
      f_q         <= f_d;
      co_q        <= co_d;
      aeqb_q      <= aeqb_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.f         = f_q;
  assign bus.co        = co_q;
  assign bus.aeqb      = aeqb_q;
  assign bus.zero      = zero_q;

endmodule
